uart_tx_fifo: RTL

Buffered UART transmitter: accepts bytes over a single-cycle write strobe into an internal FIFO and serializes them 8N1, LSB first, on `uart_tx`. Consecutive bytes go out back-to-back with no idle gap. It sits between the SRAM/command logic in `top` and the board TX pin. Callers push bytes whenever `wr_ready` is high and no longer run their own SEND/WAIT handshake against a busy flag.

---
 rtl/uart_pkg.sv | 15 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: default bit timing,
// frame length, serializer state encoding and the byte type.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int FRAME_BITS          = 10;   // start + 8 data + stop

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a show-ahead read port. Storage is not reset;
// only the pointers and occupancy count are. A push is refused whenever the
// FIFO is full at the start of the cycle, even if a pop happens in that cycle.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_enable,
  input  byte_t             wr_data,
  input  logic              rd_enable,
  output byte_t             rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  byte_t             mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = wr_enable && !full;
  assign do_pop  = rd_enable && !empty;
  assign rd_data = mem[rd_ptr];

  // Write accepted bytes into storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Advance pointers (wrapping naturally at DEPTH) and track occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes pushed into the FIFO are serialized
// LSB first; when a frame ends with more data queued, the next frame starts
// on the very next cycle so frames go out back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_enable,
  input  logic [7:0]      wr_data,
  output logic            wr_ready,
  output logic            overflow,
  output logic [ADDR_W:0] count,
  output logic            uart_busy,
  output logic            uart_tx
);

  localparam int              CNT_W    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

  tx_state_t              state;
  tx_state_t              state_nxt;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [FRAME_BITS-1:0]  shift_nxt;
  logic [CNT_W-1:0]       clk_cnt;
  logic [CNT_W-1:0]       clk_nxt;
  logic [3:0]             bit_cnt;
  logic [3:0]             bit_nxt;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  byte_t                  fifo_data;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .rd_enable (fifo_pop),
    .rd_data   (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign wr_ready  = ~fifo_full;
  assign uart_busy = (state == SEND) || !fifo_empty;
  assign uart_tx   = (state == SEND) ? shift_reg[0] : 1'b1;

  // Flag a push that arrived while full; high for the following cycle only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= wr_enable && fifo_full;
    end
  end

  // Serializer state register; reset leaves the line idle-high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '1;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      clk_cnt   <= clk_nxt;
      bit_cnt   <= bit_nxt;
    end
  end

  // Next-state logic: load a frame from the FIFO, shift once per bit period,
  // and at the last cycle of the stop bit either reload or return to idle.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    clk_nxt   = clk_cnt;
    bit_nxt   = bit_cnt;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_nxt = {1'b1, fifo_data, 1'b0};
          clk_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (clk_cnt == CLK_LAST) begin
          clk_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              shift_nxt = {1'b1, fifo_data, 1'b0};
            end else begin
              shift_nxt = '1;
              state_nxt = IDLE;
            end
          end else begin
            shift_nxt = {1'b1, shift_reg[FRAME_BITS-1:1]};
            bit_nxt   = bit_cnt + 1'b1;
          end
        end else begin
          clk_nxt = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
